maxnet_loader: RTL and testbench

Host-side front end for the Maxnet datapath. It accepts the four candidate numbers over a valid/ready stream and writes them into the datapath's input word bank. It then issues a start pulse, waits for the datapath's `done`, and returns the winning `maxnumber` over a second valid/ready stream. It sits between the host/testbench and the Maxnet controller+datapath, replacing the preloaded data memory as the source of the datapath's read words.

---
 rtl/maxnet_loader.sv | 139 +++++++++++++
 tb/tb_maxnet_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | maxnet_loader : loads four candidates into the Maxnet word bank,   |
// | starts the controller and returns the winner or a timeout abort.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module maxnet_loader #(
   parameter int DATA_W  = 32,
   parameter int N       = 4,
   parameter int GUARD   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [N*DATA_W-1:0] mem_data,
   output logic                start,
   input  logic                done,
   input  logic [DATA_W-1:0]   maxnumber,
   output logic [DATA_W-1:0]   res_data,
   output logic                res_err,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                busy
);

   localparam int c_WCW = (N > 1) ? $clog2(N) : 1;
   localparam int c_GCW = (GUARD > 1) ? $clog2(GUARD) : 1;
   localparam int c_TCW = $clog2(TIMEOUT + 1);

   localparam logic [c_WCW-1:0] c_WLAST = c_WCW'(N - 1);
   localparam logic [c_GCW-1:0] c_GLAST = c_GCW'(GUARD - 1);
   localparam logic [c_TCW-1:0] c_TLIM  = c_TCW'(TIMEOUT);

   localparam logic [2:0] c_LOAD    = 3'd0;
   localparam logic [2:0] c_START   = 3'd1;
   localparam logic [2:0] c_GUARD_W = 3'd2;
   localparam logic [2:0] c_RUN     = 3'd3;
   localparam logic [2:0] c_RESULT  = 3'd4;

   logic [2:0]          r_state;
   logic [c_WCW-1:0]    r_wr_cnt;
   logic [c_GCW-1:0]    r_gcnt;
   logic [c_TCW-1:0]    r_tcnt;
   logic [N*DATA_W-1:0] r_mem;
   logic                r_start;
   logic [DATA_W-1:0]   r_res_data;
   logic                r_res_err;
   logic                r_res_valid;
   logic                w_accept;

   assign in_ready  = (r_state == c_LOAD);
   assign busy      = (r_state != c_LOAD);
   assign w_accept  = in_valid & in_ready;
   assign mem_data  = r_mem;
   assign start     = r_start;
   assign res_data  = r_res_data;
   assign res_err   = r_res_err;
   assign res_valid = r_res_valid;

   // The bank is only touched by load handshakes; it survives the end of a run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem <= '0;
      end else if (w_accept) begin
         for (int i = 0; i < N; i++) begin
            if (r_wr_cnt == c_WCW'(i)) r_mem[i*DATA_W +: DATA_W] <= in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= c_LOAD;
         r_wr_cnt    <= '0;
         r_gcnt      <= '0;
         r_tcnt      <= '0;
         r_start     <= 1'b0;
         r_res_data  <= '0;
         r_res_err   <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         r_start <= 1'b0;
         case (r_state)
            c_LOAD: begin
               if (w_accept) begin
                  if (r_wr_cnt == c_WLAST) begin
                     r_wr_cnt <= '0;
                     r_start  <= 1'b1;
                     r_state  <= c_START;
                  end else begin
                     r_wr_cnt <= r_wr_cnt + 1'b1;
                  end
               end
            end
            c_START: begin
               r_gcnt  <= '0;
               r_state <= c_GUARD_W;
            end
            // done is combinational on stale datapath registers right after start
            c_GUARD_W: begin
               if (r_gcnt == c_GLAST) begin
                  r_tcnt  <= '0;
                  r_state <= c_RUN;
               end else begin
                  r_gcnt <= r_gcnt + 1'b1;
               end
            end
            c_RUN: begin
               if (done) begin
                  r_res_data  <= maxnumber;
                  r_res_err   <= 1'b0;
                  r_res_valid <= 1'b1;
                  r_state     <= c_RESULT;
               end else if (r_tcnt == c_TLIM) begin
                  r_res_data  <= '0;
                  r_res_err   <= 1'b1;
                  r_res_valid <= 1'b1;
                  r_state     <= c_RESULT;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end
            c_RESULT: begin
               if (r_res_valid && res_ready) begin
                  r_res_valid <= 1'b0;
                  r_res_err   <= 1'b0;
                  r_state     <= c_LOAD;
               end
            end
            default: r_state <= c_LOAD;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_maxnet_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_maxnet_loader : randomized scoreboard bench with host, datapath |
// | stand-in and result consumer. Rev 1.0                              |
// +--------------------------------------------------------------------+
module tb_maxnet_loader;
   localparam int DATA_W  = 32;
   localparam int N       = 4;
   localparam int GUARD   = 2;
   localparam int TIMEOUT = 255;
   localparam int MXLEN   = GUARD + TIMEOUT + 8;
   localparam int NEVER   = 1000000;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              err;
      int                lat;
   } res_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [DATA_W-1:0]   in_data = '0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [N*DATA_W-1:0] mem_data;
   logic                start;
   logic                done = 1'b0;
   logic [DATA_W-1:0]   maxnumber = '0;
   logic [DATA_W-1:0]   res_data;
   logic                res_err;
   logic                res_valid;
   logic                res_ready = 1'b0;
   logic                busy;

   maxnet_loader #(.DATA_W(DATA_W), .N(N), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mem_data(mem_data), .start(start), .done(done), .maxnumber(maxnumber),
      .res_data(res_data), .res_err(res_err), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   res_t                q_res[$];
   logic [N*DATA_W-1:0] q_bank[$];
   int                  n_cmp = 0;
   int                  n_bad = 0;
   int                  cur_d = NEVER;
   logic [DATA_W-1:0]   mx [MXLEN];
   logic [DATA_W-1:0]   w_run [N];
   logic                act = 1'b0;
   int                  s_cyc = 0;
   int                  rr_mode = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Run outcome from the rules: done is looked at only from the first RUN
   // cycle (offset GUARD+1 after the start cycle) up to GUARD+1+TIMEOUT.
   function automatic res_t model(input int d);
      res_t r;
      int   cap;
      cap = (d > GUARD + 1) ? d : GUARD + 1;
      if (cap <= GUARD + 1 + TIMEOUT) begin
         r.data = mx[cap];
         r.err  = 1'b0;
         r.lat  = cap + 1;
      end else begin
         r.data = '0;
         r.err  = 1'b1;
         r.lat  = GUARD + 2 + TIMEOUT;
      end
      return r;
   endfunction

   task automatic fill_mx_rand();
      for (int i = 0; i < MXLEN; i++) mx[i] = $urandom;
   endtask

   task automatic push_exp(input int d);
      logic [N*DATA_W-1:0] b;
      cur_d = d;
      q_res.push_back(model(d));
      for (int i = 0; i < N; i++) b[i*DATA_W +: DATA_W] = w_run[i];
      q_bank.push_back(b);
   endtask

   task automatic load_words(input logic [DATA_W-1:0] w [N], input int cnt,
                             input int stall_pct, output int cycles);
      cycles = 0;
      for (int i = 0; i < cnt; i++) begin
         while (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(posedge clk); #1;
            cycles++;
         end
         in_valid = 1'b1;
         in_data  = w[i];
         begin : accept
            int  b;
            logic got;
            b = 0;
            got = 1'b0;
            while (!got && b < 600) begin
               @(negedge clk);
               got = in_ready;
               @(posedge clk); #1;
               cycles++;
               b++;
            end
            chk("word_accepted", 128'(got), 128'd1);
         end
      end
      in_valid = 1'b0;
      in_data  = $urandom;
   endtask

   task automatic issue(input int d, input int stall, output int cycles);
      push_exp(d);
      load_words(w_run, N, stall, cycles);
   endtask

   task automatic wait_idle();
      int b;
      b = 0;
      while (q_res.size() != 0 && b < 2000) begin
         @(negedge clk);
         b++;
      end
      chk("result_drained", 128'(q_res.size()), 128'd0);
      q_res.delete();
      q_bank.delete();
   endtask

   task automatic do_reset();
      #1 rst = 1'b0;
      #1;
      chk("rst_mem_data", mem_data, 128'd0);
      chk("rst_start", 128'(start), 128'd0);
      chk("rst_res_data", 128'(res_data), 128'd0);
      chk("rst_res_err", 128'(res_err), 128'd0);
      chk("rst_res_valid", 128'(res_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      q_res.delete();
      q_bank.delete();
   endtask

   // Datapath stand-in: done is random while idle and during the guard window.
   initial begin
      int t;
      forever begin
         @(posedge clk); #1;
         if (act) begin
            t = cyc - s_cyc;
            if (t <= GUARD) done = 1'($urandom_range(0, 1));
            else            done = (t >= cur_d);
            maxnumber = mx[(t < MXLEN) ? t : MXLEN - 1];
         end else begin
            done      = 1'($urandom_range(0, 1));
            maxnumber = $urandom;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         case (rr_mode)
            1:       res_ready = 1'b0;
            2:       res_ready = 1'b1;
            default: res_ready = ($urandom_range(0, 2) != 0);
         endcase
      end
   end

   // Monitor: bank checked at each start pulse, result latency on the rising
   // edge of res_valid, payload on handshake, stability while stalled.
   initial begin
      logic              pv;
      logic              hold;
      logic [DATA_W-1:0] hd;
      logic              he;
      res_t              r;
      pv = 1'b0;
      hold = 1'b0;
      hd = '0;
      he = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            act  = 1'b0;
            pv   = 1'b0;
            hold = 1'b0;
         end else begin
            if (start) begin
               chk("start_has_pending_load", 128'(q_bank.size() != 0), 128'd1);
               if (q_bank.size() != 0) chk("bank_at_start", mem_data, q_bank.pop_front());
               act   = 1'b1;
               s_cyc = cyc;
            end
            if (hold) begin
               chk("held_res_valid", 128'(res_valid), 128'd1);
               chk("held_res_data", 128'(res_data), 128'(hd));
               chk("held_res_err", 128'(res_err), 128'(he));
            end
            if (res_valid && !pv) begin
               act = 1'b0;
               chk("result_has_pending_run", 128'(q_res.size() != 0), 128'd1);
               if (q_res.size() != 0) chk("result_latency", 128'(cyc - s_cyc), 128'(q_res[0].lat));
            end
            if (res_valid && res_ready) begin
               if (q_res.size() != 0) begin
                  r = q_res.pop_front();
                  chk("res_data", 128'(res_data), 128'(r.data));
                  chk("res_err", 128'(res_err), 128'(r.err));
               end
               hold = 1'b0;
            end else if (res_valid) begin
               hold = 1'b1;
               hd   = res_data;
               he   = res_err;
            end else begin
               hold = 1'b0;
            end
            pv = res_valid;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: run did not complete (compared %0d)", n_cmp);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int                  c;
      int                  c2;
      int                  d;
      logic [N*DATA_W-1:0] held;
      do_reset();
      @(posedge clk); #1;

      w_run = '{32'd5, 32'd9, 32'd3, 32'd7};
      for (int i = 0; i < MXLEN; i++) mx[i] = 32'd9;
      issue(GUARD + 3, 0, c);
      chk("load_cycles_no_stall", 128'(c), 128'(N));
      wait_idle();

      w_run = '{32'd1, 32'd2, 32'd3, 32'd4};
      fill_mx_rand();
      issue(GUARD + 2, 50, c);
      wait_idle();

      fill_mx_rand();
      for (int i = 0; i < N; i++) w_run[i] = $urandom;
      mx[1] = 32'hAA;
      for (int i = 2; i < MXLEN; i++) mx[i] = 32'hBB;
      issue(1, 20, c);
      wait_idle();

      fill_mx_rand();
      issue(NEVER, 20, c);
      wait_idle();

      fill_mx_rand();
      issue(GUARD + 1 + TIMEOUT, 20, c);
      wait_idle();

      // Stalled result while the host already offers the next word.
      fill_mx_rand();
      for (int i = 0; i < N; i++) w_run[i] = $urandom;
      rr_mode = 1;
      issue(GUARD + 2, 0, c);
      begin : wait_held
         int b;
         b = 0;
         while (!res_valid && b < 400) begin
            @(negedge clk);
            b++;
         end
         chk("held_result_present", 128'(res_valid), 128'd1);
      end
      held = mem_data;
      fill_mx_rand();
      w_run[0] = 32'h11;
      for (int i = 1; i < N; i++) w_run[i] = $urandom;
      push_exp(GUARD + 1);
      fork
         load_words(w_run, N, 0, c2);
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               chk("stall_in_ready", 128'(in_ready), 128'd0);
               chk("stall_busy", 128'(busy), 128'd1);
               chk("stall_mem_data", mem_data, held);
            end
            rr_mode = 2;
            begin : wait_hs
               int b;
               b = 0;
               @(negedge clk);
               while (!(res_valid && res_ready) && b < 10) begin
                  @(negedge clk);
                  b++;
               end
            end
            @(negedge clk);
            chk("in_ready_after_result", 128'(in_ready), 128'd1);
            @(negedge clk);
            chk("entry0_after_result", 128'(mem_data[DATA_W-1:0]), 128'h11);
         end
      join
      rr_mode = 0;
      wait_idle();

      // Reset in the guard window, then reset part-way through a load.
      fill_mx_rand();
      for (int i = 0; i < N; i++) w_run[i] = $urandom | 32'h1;
      issue(GUARD + 2, 0, c);
      @(posedge clk); #1;
      chk("guard_busy", 128'(busy), 128'd1);
      chk("guard_in_ready", 128'(in_ready), 128'd0);
      do_reset();
      @(posedge clk); #1;
      load_words(w_run, 2, 0, c);
      do_reset();
      @(posedge clk); #1;

      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < N; i++) w_run[i] = $urandom;
         fill_mx_rand();
         case ($urandom_range(0, 9))
            0:       d = NEVER;
            1:       d = GUARD + 1 + TIMEOUT;
            2:       d = GUARD + TIMEOUT;
            default: d = int'($urandom_range(1, GUARD + 6));
         endcase
         issue(d, 30, c);
         wait_idle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
